// File: rtl/async_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module   : async_fifo_reader
// Purpose  : Read-side drain engine for the asynchronous FIFO. Lives entirely
//            in the read clock domain. It pops the FIFO against `empty`,
//            absorbs the one-cycle FIFO read latency in a 2-entry skid
//            buffer, and presents the words as a valid/ready stream framed
//            into fixed-length packets with `out_last`.
// Ports    : r_clk     - read-domain clock (rising edge)
//            r_rst     - asynchronous active-low reset
//            enable    - allows new pops to be issued
//            empty     - FIFO empty flag (r_clk domain)
//            rd_data   - FIFO read data, valid one cycle after a pop
//            rd        - FIFO pop request
//            out_data  - head-of-stream word
//            out_valid - out_data is valid
//            out_ready - downstream accepts the head word
//            out_last  - head word is the last word of its packet
// Revision : 1.0 - initial release
// ============================================================================
module async_fifo_reader #(
  parameter int width   = 8,
  parameter int pkt_len = 4
) (
  input  logic             r_clk,
  input  logic             r_rst,
  input  logic             enable,
  input  logic             empty,
  input  logic [width-1:0] rd_data,
  output logic             rd,
  output logic [width-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);

  localparam int                 BEAT_W    = (pkt_len > 1) ? $clog2(pkt_len) : 1;
  localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(pkt_len - 1);

  logic              infl_q, infl_d;
  logic [1:0]        occ_q,  occ_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [width-1:0]  head_q, head_d;
  logic [width-1:0]  tail_q, tail_d;

  logic              w_pop_out;
  logic [2:0]        w_level;

  always_comb begin
    w_pop_out = (occ_q != 2'd0) && out_ready;
    // Words owned by this block after this edge: buffered plus in flight,
    // minus the one leaving. Never exceeds 2 because rd is gated on it.
    w_level   = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, w_pop_out};

    // The reset term keeps the pop request quiet while the block is held
    // in reset, even though all other inputs may be active.
    rd        = r_rst && enable && !empty && (w_level < 3'd2);

    infl_d    = rd;
    occ_d     = w_level[1:0];

    head_d    = head_q;
    tail_d    = tail_q;
    if (w_pop_out) begin
      head_d = tail_q;
    end
    // The arriving word lands in the head slot whenever the head will be
    // vacant after this edge; otherwise it queues behind in the tail.
    if (infl_q) begin
      if ((occ_q == 2'd0) || (w_pop_out && (occ_q == 2'd1))) begin
        head_d = rd_data;
      end else begin
        tail_d = rd_data;
      end
    end

    beat_d = beat_q;
    if (w_pop_out) begin
      if (beat_q == LAST_BEAT) begin
        beat_d = '0;
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end
  end

  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      infl_q <= 1'b0;
      occ_q  <= 2'd0;
      beat_q <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      infl_q <= infl_d;
      occ_q  <= occ_d;
      beat_q <= beat_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign out_valid = (occ_q != 2'd0);
  assign out_data  = head_q;
  assign out_last  = out_valid && (beat_q == LAST_BEAT);

endmodule
`default_nettype wire

// File: tb/tb_async_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_async_fifo_reader
// Purpose  : Self-checking bench for async_fifo_reader. A queue models the
//            FIFO contents; each accepted pop pushes the expected word into a
//            scoreboard that an independent monitor drains on handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_async_fifo_reader;

  localparam int W   = 8;
  localparam int PKT = 4;

  logic         r_clk = 1'b0;
  logic         r_rst = 1'b0;
  logic         enable = 1'b0;
  logic         empty = 1'b1;
  logic [W-1:0] rd_data = '0;
  logic         out_ready = 1'b0;
  logic         rd;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_last;

  always #5 r_clk = ~r_clk;

  async_fifo_reader #(.width(W), .pkt_len(PKT)) dut (
    .r_clk    (r_clk),
    .r_rst    (r_rst),
    .enable   (enable),
    .empty    (empty),
    .rd_data  (rd_data),
    .rd       (rd),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last)
  );

  int           tests = 0;
  int           fails = 0;
  int           cyc   = 0;
  logic [W-1:0] fifo[$];
  logic [W-1:0] exp_data[$];
  int           exp_cyc[$];
  int           delivered = 0;
  logic [W-1:0] next_word = '0;
  logic         last_acc;
  logic         last_rd;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // A word is visible at the output two sample points after its pop.
  function automatic logic front_ok();
    return (exp_data.size() > 0) && (exp_cyc[0] + 2 <= cyc);
  endfunction

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      fifo.push_back(next_word);
      next_word = next_word + 1'b1;
    end
  endtask

  // One clock cycle: drive inputs, check the pop request, model the FIFO.
  task automatic step(input logic rst_v, input logic en, input logic force_empty, input logic rdy);
    int   pending;
    logic exp_rd;
    @(negedge r_clk);
    r_rst     = rst_v;
    enable    = en;
    out_ready = rdy;
    empty     = force_empty || (fifo.size() == 0);
    if (!rst_v) begin
      exp_data.delete();
      exp_cyc.delete();
    end
    #3;
    if (!rst_v) begin
      chk("rst_rd", {31'd0, rd}, 32'd0);
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_last", {31'd0, out_last}, 32'd0);
      chk("rst_data", {24'd0, out_data}, 32'd0);
    end else begin
      pending = exp_data.size() - ((front_ok() && rdy) ? 1 : 0);
      exp_rd  = en && !empty && (pending < 2);
      chk("rd", {31'd0, rd}, {31'd0, exp_rd});
    end
    last_rd  = rd;
    last_acc = rd && !empty;
    if (last_acc) begin
      exp_data.push_back(fifo[0]);
      exp_cyc.push_back(cyc);
    end
    @(posedge r_clk);
    cyc++;
    #1;
    if (last_acc) rd_data = fifo.pop_front();
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (fifo.size() > 0 || exp_data.size() > 0); i++)
      step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("drain_done", fifo.size() + exp_data.size(), 32'd0);
  endtask

  // Monitor: compares the presented head word against the scoreboard.
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data  = '0;
  logic         prev_last  = 1'b0;
  initial begin
    forever begin
      @(negedge r_clk);
      #4;
      if (!r_rst) begin
        delivered  = 0;
        prev_stall = 1'b0;
      end else begin
        chk("valid", {31'd0, out_valid}, {31'd0, front_ok()});
        if (prev_stall) begin
          chk("stall_data", {24'd0, out_data}, {24'd0, prev_data});
          chk("stall_last", {31'd0, out_last}, {31'd0, prev_last});
        end
        if (front_ok()) begin
          chk("data", {24'd0, out_data}, {24'd0, exp_data[0]});
          chk("last", {31'd0, out_last}, {31'd0, (delivered % PKT) == PKT - 1});
          if (out_ready) begin
            void'(exp_data.pop_front());
            void'(exp_cyc.pop_front());
            delivered++;
          end
        end else begin
          chk("last_idle", {31'd0, out_last}, 32'd0);
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
      end
    end
  end

  initial begin
    int cnt;
    // Reset held with pops otherwise possible.
    next_word = 8'hA0;
    load(4);
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("rd_after_release", {31'd0, last_rd}, 32'd1);
    drain();

    // Streaming: 8 pops back to back, all delivered by two cycles later.
    next_word = 8'h10;
    load(8);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b1);
      if (last_acc) cnt++;
    end
    chk("stream_pops", cnt, 32'd8);
    repeat (2) step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("stream_drained", exp_data.size(), 32'd0);

    // Backpressure mid-stream.
    load(12);
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b1);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      if (last_acc) cnt++;
    end
    chk("bp_pops_le2", {31'd0, cnt <= 2}, 32'd1);
    drain();

    // Empty toggling every cycle.
    load(12);
    for (int i = 0; i < 24; i++) step(1'b1, 1'b1, i[0], 1'b1);
    drain();

    // Enable drop right after a pop.
    load(7);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1);
      if (last_acc) cnt++;
    end
    chk("en_low_pops", cnt, 32'd0);
    drain();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if (fifo.size() < 3 && ($urandom % 4) == 0) load($urandom_range(1, 6));
      step(1'b1, ($urandom % 4) != 0, ($urandom % 3) == 0, $urandom % 2);
    end
    drain();

    // Mid-packet reset with the buffer full.
    load(12);
    for (int i = 0; i < 20 && (delivered % PKT) != 2; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("mid_pkt_align", delivered % PKT, 32'd2);
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    fifo.delete();
    load(8);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
